// File: rtl/alu_seq_n_bits.sv
// alu_seq_n_bits: registered N-bit ALU with a start/done handshake.
// Single-cycle ops finish one cycle after acceptance. Multiply uses
// shift-add and divide/modulo use restoring division, one bit per cycle,
// so those ops take N+1 cycles. All results and flags are registered and
// hold until the next done pulse.
module alu_seq_n_bits #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         v,
    output logic         c,
    output logic         n,
    output logic         z,
    output logic         div_zero
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [N-1:0]  N_LIM    = N'(N);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LSR = 4'd5;
    localparam logic [3:0] OP_LSL = 4'd6;
    localparam logic [3:0] OP_MOD = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_MUL  = 3'd2,
        S_DIV  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t          state_r;
    logic [3:0]      op_r;
    logic [N-1:0]    a_r;
    logic [N-1:0]    b_r;
    logic [N-1:0]    acc_hi_r;
    logic [N-1:0]    acc_lo_r;
    logic [CW-1:0]   cnt_r;

    logic            ready_r;
    logic            busy_r;
    logic            done_r;
    logic [N-1:0]    result_r;
    logic [N-1:0]    result_hi_r;
    logic            v_r;
    logic            c_r;
    logic            n_r;
    logic            z_r;
    logic            dz_r;

    logic [N-1:0]    res_s;
    logic [N-1:0]    res_hi_s;
    logic            v_s;
    logic            c_s;
    logic            dz_s;
    logic [N:0]      add_s;
    logic [N-1:0]    bx_s;
    logic [N:0]      mul_sum_s;
    logic [N:0]      div_shift_s;
    logic [N:0]      div_trial_s;

    // One iteration of shift-add multiply and restoring division on the accumulator.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, a_r} : {(N+1){1'b0}});
        div_shift_s = {acc_hi_r, acc_lo_r[N-1]};
        div_trial_s = div_shift_s - {1'b0, b_r};
    end

    // Final result and flags for the latched op; mul/div read the finished accumulator.
    always_comb begin
        res_s    = {N{1'b0}};
        res_hi_s = {N{1'b0}};
        v_s      = 1'b0;
        c_s      = 1'b0;
        dz_s     = 1'b0;
        bx_s     = b_r;
        add_s    = {(N+1){1'b0}};
        case (op_r)
            OP_ADD: begin
                bx_s  = b_r;
                add_s = {1'b0, a_r} + {1'b0, bx_s};
                res_s = add_s[N-1:0];
                c_s   = add_s[N];
                v_s   = (a_r[N-1] == bx_s[N-1]) && (add_s[N-1] != a_r[N-1]);
            end
            OP_SUB: begin
                bx_s  = ~b_r;
                add_s = {1'b0, a_r} + {1'b0, bx_s} + {{N{1'b0}}, 1'b1};
                res_s = add_s[N-1:0];
                c_s   = add_s[N];
                v_s   = (a_r[N-1] == bx_s[N-1]) && (add_s[N-1] != a_r[N-1]);
            end
            OP_AND: res_s = a_r & b_r;
            OP_OR:  res_s = a_r | b_r;
            OP_XOR: res_s = a_r ^ b_r;
            OP_LSR: begin
                if (b_r >= N_LIM) begin
                    res_s = {N{1'b0}};
                end else begin
                    res_s = a_r >> b_r;
                end
            end
            OP_LSL: begin
                if (b_r >= N_LIM) begin
                    res_s = {N{1'b0}};
                end else begin
                    res_s = a_r << b_r;
                end
            end
            OP_MUL: begin
                res_s    = acc_lo_r;
                res_hi_s = acc_hi_r;
                c_s      = |acc_hi_r;
                v_s      = |acc_hi_r;
            end
            OP_DIV: begin
                if (b_r == {N{1'b0}}) begin
                    dz_s = 1'b1;
                end else begin
                    res_s    = acc_lo_r;
                    res_hi_s = acc_hi_r;
                end
            end
            OP_MOD: begin
                if (b_r == {N{1'b0}}) begin
                    dz_s = 1'b1;
                end else begin
                    res_s = acc_hi_r;
                end
            end
            default: begin
                res_s = {N{1'b0}};
            end
        endcase
    end

    // Control FSM: accepts requests, iterates mul/div, and registers results on done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            op_r        <= 4'd0;
            a_r         <= {N{1'b0}};
            b_r         <= {N{1'b0}};
            acc_hi_r    <= {N{1'b0}};
            acc_lo_r    <= {N{1'b0}};
            cnt_r       <= {CW{1'b0}};
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            result_r    <= {N{1'b0}};
            result_hi_r <= {N{1'b0}};
            v_r         <= 1'b0;
            c_r         <= 1'b0;
            n_r         <= 1'b0;
            z_r         <= 1'b0;
            dz_r        <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start && ready_r) begin
                        op_r    <= op;
                        a_r     <= a;
                        b_r     <= b;
                        cnt_r   <= {CW{1'b0}};
                        ready_r <= 1'b0;
                        if (op == OP_MUL) begin
                            state_r  <= S_MUL;
                            busy_r   <= 1'b1;
                            acc_hi_r <= {N{1'b0}};
                            acc_lo_r <= b;
                        end else if ((op == OP_DIV) || (op == OP_MOD)) begin
                            state_r  <= S_DIV;
                            busy_r   <= 1'b1;
                            acc_hi_r <= {N{1'b0}};
                            acc_lo_r <= a;
                        end else begin
                            state_r <= S_EXEC;
                        end
                    end
                end
                S_MUL: begin
                    acc_hi_r <= mul_sum_s[N:1];
                    acc_lo_r <= {mul_sum_s[0], acc_lo_r[N-1:1]};
                    cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= S_FIN;
                        busy_r  <= 1'b0;
                    end
                end
                S_DIV: begin
                    // Restore (keep the shifted value) when the trial subtraction borrows.
                    if (!div_trial_s[N]) begin
                        acc_hi_r <= div_trial_s[N-1:0];
                        acc_lo_r <= {acc_lo_r[N-2:0], 1'b1};
                    end else begin
                        acc_hi_r <= div_shift_s[N-1:0];
                        acc_lo_r <= {acc_lo_r[N-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= S_FIN;
                        busy_r  <= 1'b0;
                    end
                end
                S_EXEC, S_FIN: begin
                    state_r     <= S_IDLE;
                    ready_r     <= 1'b1;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b1;
                    result_r    <= res_s;
                    result_hi_r <= res_hi_s;
                    v_r         <= v_s;
                    c_r         <= c_s;
                    n_r         <= res_s[N-1];
                    z_r         <= (res_s == {N{1'b0}});
                    dz_r        <= dz_s;
                end
                default: begin
                    state_r <= S_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign result_hi = result_hi_r;
    assign v         = v_r;
    assign c         = c_r;
    assign n         = n_r;
    assign z         = z_r;
    assign div_zero  = dz_r;

endmodule
